// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DEF_WIDTH_A = 10;
    localparam int unsigned DEF_WIDTH_B = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module divider_step #(
    parameter int unsigned WIDTH_B = 8
) (
    input  logic [WIDTH_B-1:0] rem_i,
    input  logic               bit_i,
    input  logic [WIDTH_B-1:0] b_i,
    output logic [WIDTH_B-1:0] rem_o,
    output logic               q_o
);

    logic [WIDTH_B:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, b_i});
        // The result is below b whenever the subtraction happens, so the low bits suffice.
        rem_o   = q_o ? (shifted[WIDTH_B-1:0] - b_i) : shifted[WIDTH_B-1:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_INBUF_EN to add a one-entry input buffer for back-to-back operation.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH_A = DEF_WIDTH_A,
    parameter int unsigned WIDTH_B = DEF_WIDTH_B,
    parameter int unsigned WIDTH_C = WIDTH_A + WIDTH_B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_valid,
    input  logic [WIDTH_C-1:0] c,
    input  logic [WIDTH_B-1:0] b,
    output logic               ready,
    output logic               out_valid,
    output logic [WIDTH_A-1:0] q,
    output logic [WIDTH_B-1:0] r,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned CNT_W = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_B-1:0] rem_q, rem_d;
    logic [WIDTH_A-1:0] work_q, work_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    logic [WIDTH_A-1:0] q_q, q_d;
    logic [WIDTH_B-1:0] r_q, r_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               launch;
    logic               buf_full;
    logic [WIDTH_C-1:0] buf_c;
    logic [WIDTH_B-1:0] buf_b;
    logic [WIDTH_C-1:0] src_c;
    logic [WIDTH_B-1:0] src_b;
    logic [WIDTH_B-1:0] step_rem;
    logic               step_q;

    assign accept = data_valid && ready;

`ifdef DIVIDER_INBUF_EN
    logic               buf_full_q, buf_full_d;
    logic [WIDTH_C-1:0] buf_c_q, buf_c_d;
    logic [WIDTH_B-1:0] buf_b_q, buf_b_d;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_c_d    = buf_c_q;
        buf_b_d    = buf_b_q;
        if (state_q == DONE && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        if (accept && state_q == CALC) begin
            buf_full_d = 1'b1;
            buf_c_d    = c;
            buf_b_d    = b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            buf_c_q    <= '0;
            buf_b_q    <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_c_q    <= buf_c_d;
            buf_b_q    <= buf_b_d;
        end
    end

    assign buf_full = buf_full_q;
    assign buf_c    = buf_c_q;
    assign buf_b    = buf_b_q;
    assign ready    = (state_q == IDLE) || !buf_full_q;
`else
    assign buf_full = 1'b0;
    assign buf_c    = '0;
    assign buf_b    = '0;
    assign ready    = (state_q == IDLE);
`endif

    // A launch from DONE takes the buffered op if present, else a same-cycle accept.
    assign src_c  = buf_full ? buf_c : c;
    assign src_b  = buf_full ? buf_b : b;
    assign launch = (state_q == IDLE && accept) || (state_q == DONE && (buf_full || accept));

    divider_step #(.WIDTH_B(WIDTH_B)) u_step (
        .rem_i (rem_q),
        .bit_i (work_q[WIDTH_A-1]),
        .b_i   (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        work_d      = work_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (launch) begin
                    b_d = src_b;
                    if (src_b == '0) begin
                        state_d     = DONE;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        q_d         = '1;
                        r_d         = '0;
                        out_valid_d = 1'b1;
                    end else if (src_c[WIDTH_C-1:WIDTH_A] >= src_b) begin
                        state_d     = DONE;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        q_d         = '1;
                        r_d         = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = src_c[WIDTH_C-1:WIDTH_A];
                        work_d  = src_c[WIDTH_A-1:0];
                        cnt_d   = CNT_W'(WIDTH_A - 1);
                    end
                end
            end
            CALC: begin
                // Dividend bits leave the top of work while quotient bits enter the bottom.
                rem_d  = step_rem;
                work_d = {work_q[WIDTH_A-2:0], step_q};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    q_d         = {work_q[WIDTH_A-2:0], step_q};
                    r_d         = step_rem;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            work_q      <= '0;
            b_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            b_q         <= b_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
